kamus_ex_stage: RTL and testbench
=================================

Name: kamus_ex_stage

Overview:
- Execute stage of the kamus-v pipeline, directly upstream of the LSU.
- Takes decoded operands and control from the ID/EX register and computes the ALU result, including an iterative divider.
- Drives the EX/MEM pipeline register that the LSU consumes: address/ALU result, store data, and memory/regfile write enables.
- Stalls the upstream stages while a divide is in progress.

Parameters:
- XLEN, 32, datapath width; the divider runs XLEN iterations.
- DIV_EN, 1. When 0, the divider is removed: DIV/DIVU/REM/REMU return 0 in one cycle with no stall.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Synchronous, active-low.
- valid_idex_i  in  1  ID/EX holds a valid instruction.
- pc_idex_i  in  XLEN  instruction PC.
- rs1_idex_i  in  XLEN  rs1 value.
- rs2_idex_i  in  XLEN  rs2 value.
- imm_idex_i  in  XLEN  sign-extended immediate.
- alu_op_idex_i  in  4  operation code (see Behaviour).
- src_a_sel_idex_i  in  1  operand A select: 0 = rs1, 1 = pc.
- src_b_sel_idex_i  in  1  operand B select: 0 = rs2, 1 = imm.
- rd_idex_i  in  5  destination register.
- l1d_wr_en_idex_i  in  1  store.
- regfile_wr_en_idex_i  in  1  writes rd.
- flush_i  in  1  kill the instruction in EX.
- stall_o  out  1  hold IF/ID and ID/EX; their contents must stay stable while high.
- valid_exmem_reg_o  out  1  EX/MEM holds a valid instruction.
- alu_rslt_exmem_reg_o  out  XLEN  result / L1D address.
- rs2_exmem_reg_o  out  XLEN  store data.
- rd_exmem_reg_o  out  5  destination register.
- l1d_wr_en_exmem_reg_o  out  1  store enable to LSU.
- regfile_wr_en_exmem_o  out  1  regfile write enable to LSU.

Behaviour:
- Operands: A = src_a_sel ? pc : rs1; B = src_b_sel ? imm : rs2.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL: low XLEN bits of the product, single cycle.
  - 11 DIV, 12 DIVU, 13 REM, 14 REMU.
  - 15 PASSB: result = B.
- Shift amount = B[4:0]. SLT/SLTU return 0 or 1. Arithmetic wraps modulo 2^XLEN.
- Non-divide ops: result is registered into EX/MEM at the next rising edge (1-cycle latency). stall_o stays 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when valid_idex_i is high, a divide op is present and flush_i is low. stall_o goes high combinationally in that same cycle.
  - In IDLE the FSM latches |A|, |B|, the signs and the op. It clears the iteration counter.
  - BUSY: one restoring shift/subtract step per cycle. After XLEN steps (counter == XLEN-1) -> DONE. stall_o stays high.
  - DONE: stall_o = 0. The sign-corrected quotient or remainder is written to EX/MEM at this edge, then IDLE.
  - A divide therefore occupies EX for XLEN+2 cycles (34 at default). There is no early exit.
- Divide special cases use the same latency; the result is overridden:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (dividend 0x80000000, divisor -1): DIV returns 0x80000000; REM returns 0.
  - Remainder sign follows the dividend.
- While stall_o = 1, EX/MEM is loaded with a bubble: valid, l1d_wr_en and regfile_wr_en are 0. Data fields hold their previous values.
- flush_i has priority over everything:
  - The FSM goes to IDLE and stall_o is 0 in that cycle.
  - EX/MEM receives a bubble at the next edge.
- valid_idex_i = 0 outside a divide: EX/MEM receives a bubble.
- Reset (rst_ni = 0 at an edge), including mid-divide:
  - FSM goes to IDLE and the counter clears.
  - All EX/MEM outputs go to 0. stall_o is 0 from the cycle after reset.

Test Plan:
- Reset, then ADD with rs1 = 5, imm = 7, src_b_sel = 1 -> one edge later alu_rslt = 12, valid = 1, regfile_wr_en = 1, stall_o = 0.
- SRA with rs1 = 0x80000000, B = 4 -> 0xF8000000. SLTU with 1 vs 0xFFFFFFFF -> 1. SUB 0 - 1 -> 0xFFFFFFFF.
- DIV -7 / 2 -> stall_o high for 33 cycles; EX/MEM has bubbles meanwhile; then result 0xFFFFFFFD (-3) in cycle 34. REM -7 / 2 -> 0xFFFFFFFF (-1).
- DIVU 9 / 0 -> 0xFFFFFFFF; REMU 9 / 0 -> 9; DIV 0x80000000 / -1 -> 0x80000000. All with latency 34.
- Store: src_b_sel = 1, rs1 = 0x100, imm = 8, rs2 = 0xDEAD, l1d_wr_en = 1 -> alu_rslt = 0x108, rs2_exmem = 0xDEAD, l1d_wr_en_exmem = 1.
- Flush at BUSY cycle 10 -> stall_o = 0 that cycle, bubble in EX/MEM. A following ADD completes normally. Reset at BUSY cycle 5 -> all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/kamus_ex_stage.sv
// kamus-v execute stage: operand select, single-cycle ALU, iterative restoring
// divider, and the EX/MEM pipeline register feeding the LSU.
module kamus_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_idex_i,
    input  logic [XLEN-1:0] pc_idex_i,
    input  logic [XLEN-1:0] rs1_idex_i,
    input  logic [XLEN-1:0] rs2_idex_i,
    input  logic [XLEN-1:0] imm_idex_i,
    input  logic [3:0]      alu_op_idex_i,
    input  logic            src_a_sel_idex_i,
    input  logic            src_b_sel_idex_i,
    input  logic [4:0]      rd_idex_i,
    input  logic            l1d_wr_en_idex_i,
    input  logic            regfile_wr_en_idex_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_exmem_reg_o,
    output logic [XLEN-1:0] alu_rslt_exmem_reg_o,
    output logic [XLEN-1:0] rs2_exmem_reg_o,
    output logic [4:0]      rd_exmem_reg_o,
    output logic            l1d_wr_en_exmem_reg_o,
    output logic            regfile_wr_en_exmem_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SLT   = 4'd3,
        OP_SLTU  = 4'd4,
        OP_XOR   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_OR    = 4'd8,
        OP_AND   = 4'd9,
        OP_MUL   = 4'd10,
        OP_DIV   = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REM   = 4'd13,
        OP_REMU  = 4'd14,
        OP_PASSB = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_e;

    alu_op_e         op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_rslt;
    logic            is_div_op;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_start;

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_raw_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            rem_sel_q;
    logic            zero_q;
    logic            ovf_q;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_rslt;

    always_comb begin
        op        = alu_op_e'(alu_op_idex_i);
        op_a      = src_a_sel_idex_i ? pc_idex_i : rs1_idex_i;
        op_b      = src_b_sel_idex_i ? imm_idex_i : rs2_idex_i;
        is_div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        op_signed = (op == OP_DIV) || (op == OP_REM);
        op_rem    = (op == OP_REM) || (op == OP_REMU);
        a_neg     = op_signed & op_a[XLEN-1];
        b_neg     = op_signed & op_b[XLEN-1];
        div_start = DIV_EN && valid_idex_i && is_div_op && !flush_i;
    end

    always_comb begin
        alu_rslt = '0;
        case (op)
            OP_ADD:   alu_rslt = op_a + op_b;
            OP_SUB:   alu_rslt = op_a - op_b;
            OP_SLL:   alu_rslt = op_a << op_b[SHW-1:0];
            OP_SLT:   alu_rslt = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_rslt = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:   alu_rslt = op_a ^ op_b;
            OP_SRL:   alu_rslt = op_a >> op_b[SHW-1:0];
            OP_SRA:   alu_rslt = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            OP_OR:    alu_rslt = op_a | op_b;
            OP_AND:   alu_rslt = op_a & op_b;
            OP_MUL:   alu_rslt = op_a * op_b;
            OP_PASSB: alu_rslt = op_b;
            // divides never reach this path when the divider exists; without it they return 0
            default:  alu_rslt = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_o = div_start;
                if (div_start) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
    end

    // operands are held as magnitudes; signs are re-applied once the loop ends
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            dvd_raw_q <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
            if (div_start) begin
                dvd_raw_q <= op_a;
                dvs_q     <= b_neg ? -op_b : op_b;
                quo_q     <= a_neg ? -op_a : op_a;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                rem_sel_q <= op_rem;
                zero_q    <= (op_b == '0);
                ovf_q     <= op_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
            end
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        if (zero_q) begin
            quo_fix = '1;
            rem_fix = dvd_raw_q;
        end else if (ovf_q) begin
            quo_fix = dvd_raw_q;
            rem_fix = '0;
        end
        div_rslt = rem_sel_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_exmem_reg_o     <= 1'b0;
            alu_rslt_exmem_reg_o  <= '0;
            rs2_exmem_reg_o       <= '0;
            rd_exmem_reg_o        <= '0;
            l1d_wr_en_exmem_reg_o <= 1'b0;
            regfile_wr_en_exmem_o <= 1'b0;
        end else begin
            valid_exmem_reg_o     <= 1'b0;
            l1d_wr_en_exmem_reg_o <= 1'b0;
            regfile_wr_en_exmem_o <= 1'b0;
            if (!flush_i) begin
                if (state_q == S_DONE) begin
                    valid_exmem_reg_o     <= valid_idex_i;
                    alu_rslt_exmem_reg_o  <= div_rslt;
                    rs2_exmem_reg_o       <= rs2_idex_i;
                    rd_exmem_reg_o        <= rd_idex_i;
                    l1d_wr_en_exmem_reg_o <= valid_idex_i & l1d_wr_en_idex_i;
                    regfile_wr_en_exmem_o <= valid_idex_i & regfile_wr_en_idex_i;
                end else if (!stall_o && valid_idex_i) begin
                    valid_exmem_reg_o     <= 1'b1;
                    alu_rslt_exmem_reg_o  <= alu_rslt;
                    rs2_exmem_reg_o       <= rs2_idex_i;
                    rd_exmem_reg_o        <= rd_idex_i;
                    l1d_wr_en_exmem_reg_o <= l1d_wr_en_idex_i;
                    regfile_wr_en_exmem_o <= regfile_wr_en_idex_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_kamus_ex_stage.sv
// Bench for kamus_ex_stage: table-driven ALU vectors plus divide, flush and
// reset sequences, all checked through an expected-result queue.
module tb_kamus_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  alu_op;
    logic        asel, bsel;
    logic [4:0]  rd;
    logic        st, wr;
    logic        flush;
    logic        stall_o;
    logic        valid_exmem_reg_o;
    logic [31:0] alu_rslt_exmem_reg_o;
    logic [31:0] rs2_exmem_reg_o;
    logic [4:0]  rd_exmem_reg_o;
    logic        l1d_wr_en_exmem_reg_o;
    logic        regfile_wr_en_exmem_o;

    always #5 clk = ~clk;

    kamus_ex_stage #(.XLEN(32), .DIV_EN(1'b1)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .valid_idex_i          (valid),
        .pc_idex_i             (pc),
        .rs1_idex_i            (rs1),
        .rs2_idex_i            (rs2),
        .imm_idex_i            (imm),
        .alu_op_idex_i         (alu_op),
        .src_a_sel_idex_i      (asel),
        .src_b_sel_idex_i      (bsel),
        .rd_idex_i             (rd),
        .l1d_wr_en_idex_i      (st),
        .regfile_wr_en_idex_i  (wr),
        .flush_i               (flush),
        .stall_o               (stall_o),
        .valid_exmem_reg_o     (valid_exmem_reg_o),
        .alu_rslt_exmem_reg_o  (alu_rslt_exmem_reg_o),
        .rs2_exmem_reg_o       (rs2_exmem_reg_o),
        .rd_exmem_reg_o        (rd_exmem_reg_o),
        .l1d_wr_en_exmem_reg_o (l1d_wr_en_exmem_reg_o),
        .regfile_wr_en_exmem_o (regfile_wr_en_exmem_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic        asel;
        logic        bsel;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        st;
        logic        wr;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        st;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[15];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic a_s, input logic b_s,
                         input logic [31:0] v_pc, input logic [31:0] v_rs1, input logic [31:0] v_rs2,
                         input logic [31:0] v_imm, input logic v_st, input logic v_wr,
                         input logic [31:0] exp, input bit push);
        exp_t e;
        valid  = 1'b1;
        alu_op = op;
        asel   = a_s;
        bsel   = b_s;
        pc     = v_pc;
        rs1    = v_rs1;
        rs2    = v_rs2;
        imm    = v_imm;
        rd     = id[4:0];
        st     = v_st;
        wr     = v_wr;
        if (push) begin
            e.id  = id;
            e.alu = exp;
            e.rs2 = v_rs2;
            e.rd  = id[4:0];
            e.st  = v_st;
            e.wr  = v_wr;
            sb.push_back(e);
        end
    endtask

    // every valid EX/MEM entry must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && valid_exmem_reg_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid=1 want no entry");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("alu[%0d]", mon_e.id), alu_rslt_exmem_reg_o, mon_e.alu);
                chk($sformatf("rs2[%0d]", mon_e.id), rs2_exmem_reg_o, mon_e.rs2);
                chk($sformatf("rd[%0d]", mon_e.id), {27'd0, rd_exmem_reg_o}, {27'd0, mon_e.rd});
                chk($sformatf("st[%0d]", mon_e.id), {31'd0, l1d_wr_en_exmem_reg_o}, {31'd0, mon_e.st});
                chk($sformatf("wr[%0d]", mon_e.id), {31'd0, regfile_wr_en_exmem_o}, {31'd0, mon_e.wr});
            end
        end
    end

    task automatic run_div(input int id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        int guard;
        @(negedge clk);
        issue(id, op, 1'b0, 1'b0, 32'h0, a, b, 32'h0, 1'b0, 1'b1, exp, 1'b1);
        #1;
        n = 0;
        guard = 0;
        while (stall_o && guard < 100) begin
            n++;
            if (n >= 2) chk($sformatf("div_bubble[%0d]", id), {31'd0, valid_exmem_reg_o}, 32'd0);
            @(negedge clk);
            #1;
            guard++;
        end
        chk($sformatf("div_stall_cycles[%0d]", id), n, 32'd33);
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'd0,  1'b0, 1'b1, 32'h0,    32'd5,        32'h0,        32'd7,        1'b0, 1'b1, 32'd12};
        tbl[1]  = '{4'd7,  1'b0, 1'b1, 32'h0,    32'h80000000, 32'h0,        32'd4,        1'b0, 1'b1, 32'hF8000000};
        tbl[2]  = '{4'd4,  1'b0, 1'b0, 32'h0,    32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'd1};
        tbl[3]  = '{4'd1,  1'b0, 1'b0, 32'h0,    32'd0,        32'd1,        32'h0,        1'b0, 1'b1, 32'hFFFFFFFF};
        tbl[4]  = '{4'd0,  1'b0, 1'b1, 32'h0,    32'h100,      32'hDEAD,     32'd8,        1'b1, 1'b0, 32'h108};
        tbl[5]  = '{4'd3,  1'b0, 1'b0, 32'h0,    32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 1'b1, 32'd1};
        tbl[6]  = '{4'd2,  1'b0, 1'b0, 32'h0,    32'd1,        32'h25,       32'h0,        1'b0, 1'b1, 32'h20};
        tbl[7]  = '{4'd6,  1'b0, 1'b0, 32'h0,    32'h80000000, 32'd31,       32'h0,        1'b0, 1'b1, 32'd1};
        tbl[8]  = '{4'd5,  1'b0, 1'b0, 32'h0,    32'hA5A5A5A5, 32'hFFFF0000, 32'h0,        1'b0, 1'b1, 32'h5A5AA5A5};
        tbl[9]  = '{4'd8,  1'b0, 1'b0, 32'h0,    32'hF0,       32'h0F,       32'h0,        1'b0, 1'b1, 32'hFF};
        tbl[10] = '{4'd9,  1'b0, 1'b0, 32'h0,    32'hF0F0,     32'h0FF0,     32'h0,        1'b0, 1'b1, 32'h00F0};
        tbl[11] = '{4'd10, 1'b0, 1'b0, 32'h0,    32'h10000,    32'h10001,    32'h0,        1'b0, 1'b1, 32'h00010000};
        tbl[12] = '{4'd10, 1'b0, 1'b1, 32'h0,    32'd7,        32'h0,        32'hFFFFFFFD, 1'b0, 1'b1, 32'hFFFFFFEB};
        tbl[13] = '{4'd15, 1'b0, 1'b1, 32'h0,    32'h0,        32'h0,        32'h12345678, 1'b0, 1'b1, 32'h12345678};
        tbl[14] = '{4'd0,  1'b1, 1'b1, 32'h1000, 32'hCAFE,     32'h0,        32'h20,       1'b0, 1'b1, 32'h1020};

        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        pc = '0; rs1 = '0; rs2 = '0; imm = '0; alu_op = '0;
        asel = 1'b0; bsel = 1'b0; rd = '0; st = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_valid", {31'd0, valid_exmem_reg_o}, 32'd0);
        chk("reset_alu", alu_rslt_exmem_reg_o, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            issue(i, tbl[i].op, tbl[i].asel, tbl[i].bsel, tbl[i].pc, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].imm, tbl[i].st, tbl[i].wr, tbl[i].exp, 1'b1);
            #1;
            chk($sformatf("alu_stall[%0d]", i), {31'd0, stall_o}, 32'd0);
        end
        @(negedge clk);
        valid = 1'b0;

        run_div(16, 4'd11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_div(17, 4'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_div(18, 4'd12, 32'd9,        32'd0,        32'hFFFFFFFF);
        run_div(19, 4'd14, 32'd9,        32'd0,        32'd9);
        run_div(20, 4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div(21, 4'd13, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div(22, 4'd12, 32'd100,      32'd7,        32'd14);
        run_div(23, 4'd13, 32'd7,        32'hFFFFFFFE, 32'd1);
        run_div(24, 4'd11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        run_div(25, 4'd13, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);

        // flush during the tenth busy cycle
        @(negedge clk);
        issue(26, 4'd12, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #2;
        chk("flush_bubble", {31'd0, valid_exmem_reg_o}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        issue(27, 4'd0, 1'b0, 1'b0, 32'h0, 32'd3, 32'd4, 32'h0, 1'b0, 1'b1, 32'd7, 1'b1);
        #1;
        chk("post_flush_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        valid = 1'b0;

        // reset during the fifth busy cycle
        @(negedge clk);
        issue(28, 4'd0, 1'b0, 1'b1, 32'h0, 32'h55, 32'h77, 32'h11, 1'b1, 1'b1, 32'h66, 1'b1);
        @(negedge clk);
        issue(29, 4'd11, 1'b0, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, valid_exmem_reg_o}, 32'd0);
        chk("rst_alu", alu_rslt_exmem_reg_o, 32'd0);
        chk("rst_rs2", rs2_exmem_reg_o, 32'd0);
        chk("rst_rd", {27'd0, rd_exmem_reg_o}, 32'd0);
        chk("rst_st", {31'd0, l1d_wr_en_exmem_reg_o}, 32'd0);
        chk("rst_wr", {31'd0, regfile_wr_en_exmem_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(30, 4'd0, 1'b0, 1'b0, 32'h0, 32'd10, 32'd20, 32'h0, 1'b0, 1'b1, 32'd30, 1'b1);
        #1;
        chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
